// File: rtl/fm_arbiter.sv
// fm_arbiter: two-requester round-robin front end for a fixed-latency FP multiply
// pipeline, with per-requester credit counters, result routing by tag, and flush/drain.
module fm_arbiter #(
   parameter int PIPE_LAT = 4,
   parameter int MAX_OUT  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        req1_ready,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_issue,
   input  logic [31:0] mul_result,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [31:0] rsp_data,
   input  logic        flush,
   output logic        flush_done,
   output logic [3:0]  out0_cnt,
   output logic [3:0]  out1_cnt,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

   state_t              state, state_nxt;
   logic                rr;
   logic                mul_id;
   logic                done_seen;
   logic [PIPE_LAT-1:0] tag_v;
   logic [PIPE_LAT-1:0] tag_id;
   logic                elig0, elig1, grant0, grant1, accept;
   logic                hs0, hs1, hs, winner, pipe_empty;

   // Handshake: requester N transfers in any cycle where reqN_valid && reqN_ready;
   // ready is combinational and depends on valid, credit, state and flush.
   always_comb begin
      elig0      = req0_valid && (out0_cnt < MAX_CNT);
      elig1      = req1_valid && (out1_cnt < MAX_CNT);
      grant0     = elig0 && (!elig1 || !rr);
      grant1     = elig1 && (!elig0 || rr);
      accept     = !rst && (state != DRAIN) && !flush;
      req0_ready = grant0 && accept;
      req1_ready = grant1 && accept;
      hs0        = req0_valid && req0_ready;
      hs1        = req1_valid && req1_ready;
      hs         = hs0 || hs1;
      winner     = hs1;
   end

   assign rsp0_valid = tag_v[PIPE_LAT-1] && !tag_id[PIPE_LAT-1];
   assign rsp1_valid = tag_v[PIPE_LAT-1] && tag_id[PIPE_LAT-1];
   assign rsp_data   = mul_result;
   assign pipe_empty = !(|tag_v) && !mul_issue;
   // done_seen suppresses repeat pulses while flush stays high.
   assign flush_done = (state == DRAIN) && pipe_empty && !done_seen;
   assign state_dbg  = state;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (flush)                          state_nxt = DRAIN;
            else if (req0_valid || req1_valid)  state_nxt = RUN;
         end
         RUN: begin
            if (flush)                                               state_nxt = DRAIN;
            else if (!req0_valid && !req1_valid && pipe_empty)       state_nxt = IDLE;
         end
         DRAIN: begin
            if (pipe_empty) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr        <= 1'b0;
         mul_issue <= 1'b0;
         mul_id    <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         tag_v     <= '0;
         tag_id    <= '0;
         done_seen <= 1'b0;
      end else begin
         state     <= state_nxt;
         mul_issue <= hs;
         if (hs) begin
            mul_id <= winner;
            mul_a  <= winner ? req1_a : req0_a;
            mul_b  <= winner ? req1_b : req0_b;
            // rr points away from the requester just served
            rr     <= ~winner;
         end
         tag_v[0]  <= mul_issue;
         tag_id[0] <= mul_id;
         for (int i = 1; i < PIPE_LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
         done_seen <= flush && (done_seen || flush_done);
      end
   end

   // Credit counters: a simultaneous grant and response leave the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out0_cnt <= '0;
         out1_cnt <= '0;
      end else begin
         if (hs0 && !rsp0_valid && out0_cnt < MAX_CNT)
            out0_cnt <= out0_cnt + 4'd1;
         else if (!hs0 && rsp0_valid && out0_cnt != 4'd0)
            out0_cnt <= out0_cnt - 4'd1;
         if (hs1 && !rsp1_valid && out1_cnt < MAX_CNT)
            out1_cnt <= out1_cnt + 4'd1;
         else if (!hs1 && rsp1_valid && out1_cnt != 4'd0)
            out1_cnt <= out1_cnt - 4'd1;
      end
   end

endmodule

// File: tb/tb_fm_arbiter.sv
// Testbench for fm_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of outstanding operations.
module tb_fm_arbiter;

   localparam int PIPE_LAT = 4;
   localparam int MAX_OUT  = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0, flush = 1'b0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_ready, req1_ready, mul_issue, rsp0_valid, rsp1_valid, flush_done;
   logic [31:0] mul_a, mul_b, mul_result, rsp_data;
   logic [3:0]  out0_cnt, out1_cnt;
   logic [1:0]  state_dbg;

   fm_arbiter #(.PIPE_LAT(PIPE_LAT), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .mul_a(mul_a), .mul_b(mul_b), .mul_issue(mul_issue), .mul_result(mul_result),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
      .flush(flush), .flush_done(flush_done),
      .out0_cnt(out0_cnt), .out1_cnt(out1_cnt), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // Stand-in multiply pipeline: fixed latency, ignores reset, noise when idle.
   function automatic logic [31:0] pipe_fn(input logic [31:0] a, input logic [31:0] b);
      return (a * 32'd2654435761) ^ {b[15:0], b[31:16]};
   endfunction

   logic [PIPE_LAT-1:0] pipe_v = '0;
   logic [31:0]         pipe_d [PIPE_LAT];
   logic [31:0]         noise = 32'h1234_5678;

   always @(posedge clk) begin
      pipe_v    <= {pipe_v[PIPE_LAT-2:0], mul_issue};
      pipe_d[0] <= pipe_fn(mul_a, mul_b);
      for (int i = 1; i < PIPE_LAT; i++) pipe_d[i] <= pipe_d[i-1];
      noise     <= $urandom;
   end
   assign mul_result = pipe_v[PIPE_LAT-1] ? pipe_d[PIPE_LAT-1] : noise;

   // Reference model: outstanding operations as a queue with issue/response times.
   typedef struct {
      bit          id;
      logic [31:0] a;
      logic [31:0] b;
      int          issue_cyc;
      int          due;
   } op_t;

   op_t         inflight[$];
   logic [31:0] exp_q[$];
   int          cyc, m_mode, m_rr, m_cnt0, m_cnt1;
   bit          m_fseen;
   logic [31:0] m_last_a, m_last_b;
   bit          e_ready0, e_ready1, e_rsp0, e_rsp1, e_issue, e_fdone, e_empty;
   logic [31:0] e_a, e_b, e_data;
   logic [15:0] obs_f, exp_f;
   logic [95:0] obs_d, exp_d;
   int          n_vec = 0, n_err = 0;

   task automatic model_reset();
      inflight.delete();
      exp_q.delete();
      cyc = 0; m_mode = M_IDLE; m_rr = 0; m_cnt0 = 0; m_cnt1 = 0; m_fseen = 0;
      m_last_a = '0; m_last_b = '0;
   endtask

   task automatic model_eval();
      bit el0, el1, allow;
      e_empty  = (inflight.size() == 0);
      el0      = req0_valid && (m_cnt0 < MAX_OUT);
      el1      = req1_valid && (m_cnt1 < MAX_OUT);
      allow    = (m_mode != M_DRAIN) && !flush;
      e_ready0 = el0 && (!el1 || m_rr == 0) && allow;
      e_ready1 = el1 && (!el0 || m_rr == 1) && allow;
      e_issue = 0; e_a = m_last_a; e_b = m_last_b;
      e_rsp0 = 0; e_rsp1 = 0; e_data = '0;
      foreach (inflight[i]) begin
         if (inflight[i].issue_cyc == cyc) begin
            e_issue = 1; e_a = inflight[i].a; e_b = inflight[i].b;
         end
         if (inflight[i].due == cyc) begin
            if (inflight[i].id) e_rsp1 = 1; else e_rsp0 = 1;
            e_data = pipe_fn(inflight[i].a, inflight[i].b);
         end
      end
      e_fdone = (m_mode == M_DRAIN) && e_empty && !m_fseen;
   endtask

   task automatic model_update();
      op_t op;
      if (e_issue) begin m_last_a = e_a; m_last_b = e_b; end
      while (inflight.size() > 0 && inflight[0].due == cyc) void'(inflight.pop_front());
      if (e_rsp0) m_cnt0--;
      if (e_rsp1) m_cnt1--;
      if (e_ready0 || e_ready1) begin
         op.id = e_ready1;
         op.a  = e_ready1 ? req1_a : req0_a;
         op.b  = e_ready1 ? req1_b : req0_b;
         op.issue_cyc = cyc + 1;
         op.due = cyc + 1 + PIPE_LAT;
         inflight.push_back(op);
         if (e_ready1) begin m_cnt1++; m_rr = 0; end
         else begin m_cnt0++; m_rr = 1; end
      end
      case (m_mode)
         M_IDLE:  if (flush) m_mode = M_DRAIN; else if (req0_valid || req1_valid) m_mode = M_RUN;
         M_RUN:   if (flush) m_mode = M_DRAIN; else if (!req0_valid && !req1_valid && e_empty) m_mode = M_IDLE;
         default: if (e_empty) m_mode = M_IDLE;
      endcase
      m_fseen = flush && (m_fseen || e_fdone);
      cyc++;
   endtask

   task automatic cycle_head();
      @(negedge clk);
      model_eval();
      obs_f = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mul_issue, flush_done,
               state_dbg, out0_cnt, out1_cnt};
      exp_f = {e_ready0, e_ready1, e_rsp0, e_rsp1, e_issue, e_fdone,
               2'(m_mode), 4'(m_cnt0), 4'(m_cnt1)};
      obs_d = {mul_a, mul_b, (e_rsp0 || e_rsp1) ? rsp_data : 32'h0};
      exp_d = {e_a, e_b, e_data};
   endtask

   task automatic cycle_tail();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req0_valid = 0; req1_valid = 0; flush = 0;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      req0_valid = 1; req1_valid = 1; flush = 0;
      rst = 1;
      @(negedge clk);
      n_vec++;
      if ({req0_ready, req1_ready, mul_issue, rsp0_valid, rsp1_valid, flush_done} !== 6'b0) begin
         n_err++;
         $display("FAIL reset.ctrl got=%b want=000000",
                  {req0_ready, req1_ready, mul_issue, rsp0_valid, rsp1_valid, flush_done});
      end
      n_vec++;
      if ({mul_a, mul_b} !== 64'h0) begin
         n_err++; $display("FAIL reset.operands got=%h want=0", {mul_a, mul_b});
      end
      n_vec++;
      if ({state_dbg, out0_cnt, out1_cnt} !== 10'h0) begin
         n_err++; $display("FAIL reset.state_cnt got=%h want=0", {state_dbg, out0_cnt, out1_cnt});
      end
      @(posedge clk);
      #1;
      req0_valid = 0; req1_valid = 0;
      rst = 0;
      model_reset();
   endtask

   task automatic test_single();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         req0_valid = (k == 0); req0_a = 32'h4000_0000; req0_b = 32'h4040_0000;
         cycle_head();
         n_vec++; if (obs_f !== exp_f) begin n_err++; $display("FAIL single.model_flags cyc=%0d got=%h want=%h", cyc, obs_f, exp_f); end
         n_vec++; if (obs_d !== exp_d) begin n_err++; $display("FAIL single.model_data cyc=%0d got=%h want=%h", cyc, obs_d, exp_d); end
         n_vec++;
         if ({mul_issue, rsp0_valid, rsp1_valid, out0_cnt} !== {k == 1, k == 5, 1'b0, 4'((k >= 1 && k <= 5) ? 1 : 0)}) begin
            n_err++;
            $display("FAIL single.timing cyc=%0d got issue=%b rsp0=%b rsp1=%b cnt0=%0d", k,
                     mul_issue, rsp0_valid, rsp1_valid, out0_cnt);
         end
         if (k == 5) begin
            n_vec++;
            if (rsp_data !== pipe_fn(32'h4000_0000, 32'h4040_0000)) begin
               n_err++; $display("FAIL single.rsp_data got=%h want=%h", rsp_data, pipe_fn(32'h4000_0000, 32'h4040_0000));
            end
         end
         cycle_tail();
      end
   endtask

   task automatic test_contention();
      logic [31:0] want;
      do_reset();
      for (int k = 0; k < 24; k++) begin
         req0_valid = 1; req1_valid = 1;
         req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
         cycle_head();
         n_vec++; if (obs_f !== exp_f) begin n_err++; $display("FAIL contention.model_flags cyc=%0d got=%h want=%h", cyc, obs_f, exp_f); end
         n_vec++; if (obs_d !== exp_d) begin n_err++; $display("FAIL contention.model_data cyc=%0d got=%h want=%h", cyc, obs_d, exp_d); end
         n_vec++;
         if ({req0_ready, req1_ready, mul_issue} !== {k % 2 == 0, k % 2 == 1, k >= 1}) begin
            n_err++; $display("FAIL contention.grant cyc=%0d got=%b", k, {req0_ready, req1_ready, mul_issue});
         end
         exp_q.push_back((k % 2 == 0) ? pipe_fn(req0_a, req0_b) : pipe_fn(req1_a, req1_b));
         n_vec++;
         if (k >= 1 + PIPE_LAT) begin
            want = exp_q.pop_front();
            if ({rsp0_valid, rsp1_valid, rsp_data} !== {(k - 1 - PIPE_LAT) % 2 == 0, (k - 1 - PIPE_LAT) % 2 == 1, want}) begin
               n_err++; $display("FAIL contention.rsp cyc=%0d got=%b/%b/%h want_data=%h", k, rsp0_valid, rsp1_valid, rsp_data, want);
            end
         end else if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            n_err++; $display("FAIL contention.early_rsp cyc=%0d got=%b%b", k, rsp0_valid, rsp1_valid);
         end
         cycle_tail();
      end
   endtask

   task automatic test_credit();
      int peak = 0;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         req0_valid = 1; req1_valid = 0; req0_a = $urandom; req0_b = $urandom;
         cycle_head();
         n_vec++; if (obs_f !== exp_f) begin n_err++; $display("FAIL credit.model_flags cyc=%0d got=%h want=%h", cyc, obs_f, exp_f); end
         n_vec++; if (obs_d !== exp_d) begin n_err++; $display("FAIL credit.model_data cyc=%0d got=%h want=%h", cyc, obs_d, exp_d); end
         if (k <= 6) begin
            n_vec++;
            if (req0_ready !== (k < 4 || k == 6)) begin
               n_err++; $display("FAIL credit.ready cyc=%0d got=%b want=%b", k, req0_ready, (k < 4 || k == 6));
            end
         end
         if (int'(out0_cnt) > peak) peak = int'(out0_cnt);
         cycle_tail();
      end
      n_vec++;
      if (peak != MAX_OUT) begin n_err++; $display("FAIL credit.peak got=%0d want=%0d", peak, MAX_OUT); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 18; k++) begin
         req0_valid = (k < 12); req0_a = $urandom; req0_b = $urandom;
         flush = (k >= 3 && k < 12) || (k == 14);
         cycle_head();
         n_vec++; if (obs_f !== exp_f) begin n_err++; $display("FAIL flush.model_flags cyc=%0d got=%h want=%h", cyc, obs_f, exp_f); end
         n_vec++; if (obs_d !== exp_d) begin n_err++; $display("FAIL flush.model_data cyc=%0d got=%h want=%h", cyc, obs_d, exp_d); end
         n_vec++;
         if ({rsp0_valid, flush_done} !== {k >= 5 && k <= 7, k == 8 || k == 15}) begin
            n_err++; $display("FAIL flush.drain cyc=%0d got rsp0=%b done=%b", k, rsp0_valid, flush_done);
         end
         if (k >= 3 && k < 12) begin
            n_vec++;
            if (req0_ready !== 1'b0) begin n_err++; $display("FAIL flush.ready cyc=%0d got=%b want=0", k, req0_ready); end
         end
         if (k == 9 || k == 16) begin
            n_vec++;
            if (state_dbg !== 2'd0) begin n_err++; $display("FAIL flush.idle cyc=%0d got=%0d want=0", k, state_dbg); end
         end
         cycle_tail();
      end
      flush = 0;
   endtask

   task automatic test_reset_midop();
      do_reset();
      for (int k = 0; k < 14; k++) begin
         req0_valid = (k < 2); req0_a = $urandom; req0_b = $urandom;
         if (k == 3) begin rst = 1; model_reset(); end
         if (k == 4) begin rst = 0; model_reset(); end
         cycle_head();
         n_vec++; if (obs_f !== exp_f) begin n_err++; $display("FAIL midreset.model_flags cyc=%0d got=%h want=%h", k, obs_f, exp_f); end
         n_vec++;
         if (k == 2 && out0_cnt !== 4'd2) begin
            n_err++; $display("FAIL midreset.inflight got=%0d want=2", out0_cnt);
         end else if (k >= 3 && {rsp0_valid, rsp1_valid, out0_cnt, out1_cnt} !== 10'h0) begin
            n_err++; $display("FAIL midreset.quiet cyc=%0d got rsp=%b%b cnt=%0d/%0d", k, rsp0_valid, rsp1_valid, out0_cnt, out1_cnt);
         end
         cycle_tail();
      end
   endtask

   task automatic test_random();
      int dens = 2, hold = 0;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         if (k % 50 == 0) dens = $urandom_range(0, 4);
         req0_valid = ($urandom_range(0, 3) < dens);
         req1_valid = ($urandom_range(0, 3) < dens);
         req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
         if (hold > 0) hold--;
         else if ($urandom_range(0, 39) == 0) hold = $urandom_range(1, 8);
         flush = (hold > 0);
         cycle_head();
         n_vec++; if (obs_f !== exp_f) begin n_err++; $display("FAIL random.model_flags cyc=%0d got=%h want=%h", cyc, obs_f, exp_f); end
         n_vec++; if (obs_d !== exp_d) begin n_err++; $display("FAIL random.model_data cyc=%0d got=%h want=%h", cyc, obs_d, exp_d); end
         cycle_tail();
      end
      flush = 0; req0_valid = 0; req1_valid = 0;
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_contention();
      test_credit();
      test_flush();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
